// File: rtl/scie_issue_arbiter.sv
// scie_issue_arbiter
//   Shares one pipelined SCIE custom-instruction unit between two command
//   requesters. Round-robin arbitration, registered issue onto the SCIE
//   inputs, a fixed-latency in-flight tracker that steers each io_rd result
//   back to the requester that issued the read, and push-to-read spacing.
//
// Optional feature: define SCIE_ARB_PERFCNT_EN to add perf_issue_count and
// perf_stall_count (32-bit, wrapping).
//
// Ports
//   clock, reset            clock, asynchronous active-low reset
//   reqN_valid/ready        command handshake (ready = granted this cycle)
//   reqN_insn/rs1/rs2       command fields, insn[6:0] is the opcode
//   rspN_valid/ready/data   one-entry result slot per requester
//   scie_valid/insn/rs1/rs2 registered issue to the SCIE unit
//   scie_rd                 SCIE result, valid LATENCY cycles after scie_valid
module scie_issue_arbiter #(
    parameter int XLEN     = 32,
    parameter int LATENCY  = 2,
    parameter int READ_GAP = 1
) (
    input  logic            clock,
    input  logic            reset,
    input  logic            req0_valid,
    output logic            req0_ready,
    input  logic [31:0]     req0_insn,
    input  logic [XLEN-1:0] req0_rs1,
    input  logic [XLEN-1:0] req0_rs2,
    input  logic            req1_valid,
    output logic            req1_ready,
    input  logic [31:0]     req1_insn,
    input  logic [XLEN-1:0] req1_rs1,
    input  logic [XLEN-1:0] req1_rs2,
    output logic            rsp0_valid,
    input  logic            rsp0_ready,
    output logic [XLEN-1:0] rsp0_data,
    output logic            rsp1_valid,
    input  logic            rsp1_ready,
    output logic [XLEN-1:0] rsp1_data,
    output logic            scie_valid,
    output logic [31:0]     scie_insn,
    output logic [XLEN-1:0] scie_rs1,
    output logic [XLEN-1:0] scie_rs2,
`ifdef SCIE_ARB_PERFCNT_EN
    output logic [31:0]     perf_issue_count,
    output logic [31:0]     perf_stall_count,
`endif
    input  logic [XLEN-1:0] scie_rd
);

    localparam logic [6:0] OP_PUSH = 7'h2B;
    localparam logic [6:0] OP_READ = 7'h5B;
    localparam int         GW      = (READ_GAP > 0) ? $clog2(READ_GAP + 1) : 1;

    typedef struct packed {
        logic rd;
        logic id;
    } trk_t;

    logic [1:0]                 vld, pop;
    logic [1:0][31:0]           insn;
    logic [1:0][XLEN-1:0]       rs1, rs2;

    assign vld  = {req1_valid, req0_valid};
    assign pop  = {rsp1_ready, rsp0_ready};
    assign insn = {req1_insn, req0_insn};
    assign rs1  = {req1_rs1, req0_rs1};
    assign rs2  = {req1_rs2, req0_rs2};

    logic                       last_grant_q, last_grant_d;
    logic [1:0][GW-1:0]         gap_q, gap_d;
    logic [1:0]                 rsp_valid_q, rsp_valid_d;
    logic [1:0][XLEN-1:0]       rsp_data_q, rsp_data_d;
    trk_t [LATENCY:0]           vld_pipe_q, vld_pipe_d;
    logic                       scie_valid_q, scie_valid_d;
    logic [31:0]                scie_insn_q, scie_insn_d;
    logic [XLEN-1:0]            scie_rs1_q, scie_rs1_d;
    logic [XLEN-1:0]            scie_rs2_q, scie_rs2_d;
`ifdef SCIE_ARB_PERFCNT_EN
    logic [31:0]                issue_cnt_q, issue_cnt_d;
    logic [31:0]                stall_cnt_q, stall_cnt_d;
`endif

    logic [1:0] inflight, is_rd, is_push, elig, grant;
    logic       win;

    always_comb begin
        inflight = '0;
        for (int k = 0; k <= LATENCY; k++)
            if (vld_pipe_q[k].rd) inflight[vld_pipe_q[k].id] = 1'b1;

        // Reads need an empty slot, no read in flight and an expired gap;
        // everything else only needs valid. Nothing is granted under reset.
        for (int n = 0; n < 2; n++) begin
            is_rd[n]   = (insn[n][6:0] == OP_READ);
            is_push[n] = (insn[n][6:0] == OP_PUSH);
            elig[n]    = vld[n] & reset &
                         (~is_rd[n] | (~rsp_valid_q[n] & ~inflight[n] & (gap_q[n] == '0)));
        end

        grant = '0;
        if (&elig) grant[!last_grant_q] = 1'b1;
        else       grant = elig;
        win = grant[1];

        last_grant_d = (|grant) ? win : last_grant_q;
        scie_valid_d = |grant;
        scie_insn_d  = (|grant) ? insn[win] : scie_insn_q;
        scie_rs1_d   = (|grant) ? rs1[win]  : scie_rs1_q;
        scie_rs2_d   = (|grant) ? rs2[win]  : scie_rs2_q;

        for (int n = 0; n < 2; n++) begin
            gap_d[n] = (gap_q[n] != '0) ? gap_q[n] - 1'b1 : gap_q[n];
            if (grant[n] && is_push[n]) gap_d[n] = GW'(READ_GAP);
        end

        vld_pipe_d[0] = '{rd: (|grant) & is_rd[win], id: win};
        for (int k = 1; k <= LATENCY; k++) vld_pipe_d[k] = vld_pipe_q[k-1];

        // One read credit per requester means capture and pop never hit the
        // same slot in the same cycle.
        for (int n = 0; n < 2; n++) begin
            rsp_valid_d[n] = rsp_valid_q[n];
            rsp_data_d[n]  = rsp_data_q[n];
            if (rsp_valid_q[n] && pop[n]) rsp_valid_d[n] = 1'b0;
            if (vld_pipe_q[LATENCY].rd && (vld_pipe_q[LATENCY].id == n[0])) begin
                rsp_valid_d[n] = 1'b1;
                rsp_data_d[n]  = scie_rd;
            end
        end

`ifdef SCIE_ARB_PERFCNT_EN
        issue_cnt_d = issue_cnt_q + ((|grant) ? 32'd1 : 32'd0);
        stall_cnt_d = stall_cnt_q + (((|vld) && !(|grant)) ? 32'd1 : 32'd0);
`endif
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            last_grant_q <= 1'b1;
            gap_q        <= '0;
            rsp_valid_q  <= '0;
            rsp_data_q   <= '0;
            vld_pipe_q   <= '0;
            scie_valid_q <= 1'b0;
            scie_insn_q  <= '0;
            scie_rs1_q   <= '0;
            scie_rs2_q   <= '0;
`ifdef SCIE_ARB_PERFCNT_EN
            issue_cnt_q  <= '0;
            stall_cnt_q  <= '0;
`endif
        end else begin
            last_grant_q <= last_grant_d;
            gap_q        <= gap_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_data_q   <= rsp_data_d;
            vld_pipe_q   <= vld_pipe_d;
            scie_valid_q <= scie_valid_d;
            scie_insn_q  <= scie_insn_d;
            scie_rs1_q   <= scie_rs1_d;
            scie_rs2_q   <= scie_rs2_d;
`ifdef SCIE_ARB_PERFCNT_EN
            issue_cnt_q  <= issue_cnt_d;
            stall_cnt_q  <= stall_cnt_d;
`endif
        end
    end

    assign req0_ready = grant[0];
    assign req1_ready = grant[1];
    assign rsp0_valid = rsp_valid_q[0];
    assign rsp1_valid = rsp_valid_q[1];
    assign rsp0_data  = rsp_data_q[0];
    assign rsp1_data  = rsp_data_q[1];
    assign scie_valid = scie_valid_q;
    assign scie_insn  = scie_insn_q;
    assign scie_rs1   = scie_rs1_q;
    assign scie_rs2   = scie_rs2_q;
`ifdef SCIE_ARB_PERFCNT_EN
    assign perf_issue_count = issue_cnt_q;
    assign perf_stall_count = stall_cnt_q;
`endif

endmodule

// File: tb/tb_scie_issue_arbiter.sv
// Bench for scie_issue_arbiter: directed scenarios followed by random
// traffic, all checked cycle by cycle against a cycle-count based model
// (result due-cycle, earliest-read-cycle, held result per requester).
module tb_scie_issue_arbiter;
    localparam int LAT = 2;
    localparam int GAP = 1;

    logic        clock, reset;
    logic        v    [2];
    logic [31:0] ins  [2];
    logic [31:0] s1   [2];
    logic [31:0] s2   [2];
    logic        rr   [2];
    logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [31:0] rsp0_data, rsp1_data;
    logic        scie_valid;
    logic [31:0] scie_insn, scie_rs1, scie_rs2, scie_rd;
`ifdef SCIE_ARB_PERFCNT_EN
    logic [31:0] perf_issue_count, perf_stall_count;
`endif

    scie_issue_arbiter #(.XLEN(32), .LATENCY(LAT), .READ_GAP(GAP)) dut (
        .clock(clock), .reset(reset),
        .req0_valid(v[0]), .req0_ready(req0_ready), .req0_insn(ins[0]),
        .req0_rs1(s1[0]), .req0_rs2(s2[0]),
        .req1_valid(v[1]), .req1_ready(req1_ready), .req1_insn(ins[1]),
        .req1_rs1(s1[1]), .req1_rs2(s2[1]),
        .rsp0_valid(rsp0_valid), .rsp0_ready(rr[0]), .rsp0_data(rsp0_data),
        .rsp1_valid(rsp1_valid), .rsp1_ready(rr[1]), .rsp1_data(rsp1_data),
        .scie_valid(scie_valid), .scie_insn(scie_insn),
        .scie_rs1(scie_rs1), .scie_rs2(scie_rs2),
`ifdef SCIE_ARB_PERFCNT_EN
        .perf_issue_count(perf_issue_count), .perf_stall_count(perf_stall_count),
`endif
        .scie_rd(scie_rd)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int checks = 0;
    int errors = 0;

    // reference model state
    int          cyc;
    int          m_due   [2];   // cycle from which the result is visible, -1 none
    int          m_early [2];   // earliest cycle a read may be granted
    bit          m_rv    [2];
    logic [31:0] m_rd    [2];
    bit          m_last;
    logic        m_sv;
    logic [31:0] m_si, m_s1, m_s2;
    int unsigned m_pi, m_ps;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int n = 0; n < 2; n++) begin
            m_due[n] = -1; m_early[n] = 0; m_rv[n] = 0; m_rd[n] = '0;
        end
        m_last = 1; m_sv = 0; m_si = '0; m_s1 = '0; m_s2 = '0; m_pi = 0; m_ps = 0;
    endtask

    task automatic chk_outputs();
        chk("scie_valid", 32'(scie_valid), 32'(m_sv));
        chk("scie_insn", scie_insn, m_si);
        chk("scie_rs1", scie_rs1, m_s1);
        chk("scie_rs2", scie_rs2, m_s2);
        chk("rsp0_valid", 32'(rsp0_valid), 32'(m_rv[0]));
        chk("rsp1_valid", 32'(rsp1_valid), 32'(m_rv[1]));
        chk("rsp0_data", rsp0_data, m_rd[0]);
        chk("rsp1_data", rsp1_data, m_rd[1]);
`ifdef SCIE_ARB_PERFCNT_EN
        chk("perf_issue", perf_issue_count, m_pi);
        chk("perf_stall", perf_stall_count, m_ps);
`endif
    endtask

    // Called at a negedge with inputs already driven; returns at the next negedge.
    task automatic step();
        int g;
        bit el [2];
        #1;
        for (int n = 0; n < 2; n++) begin
            bit is_rd;
            is_rd = (ins[n][6:0] == 7'h5B);
            el[n] = v[n] && (!is_rd || (!m_rv[n] && m_due[n] < 0 && cyc >= m_early[n]));
        end
        if (el[0] && el[1]) g = m_last ? 0 : 1;
        else if (el[0])     g = 0;
        else if (el[1])     g = 1;
        else                g = -1;
        chk("req0_ready", 32'(req0_ready), 32'(g == 0));
        chk("req1_ready", 32'(req1_ready), 32'(g == 1));
        @(posedge clock);
        for (int n = 0; n < 2; n++) begin
            if (m_rv[n] && rr[n]) m_rv[n] = 0;
            if (m_due[n] == cyc + 1) begin
                m_rv[n] = 1; m_rd[n] = scie_rd; m_due[n] = -1;
            end
        end
        if (g >= 0) begin
            m_sv = 1; m_si = ins[g]; m_s1 = s1[g]; m_s2 = s2[g];
            m_last = (g == 1);
            if (ins[g][6:0] == 7'h2B) m_early[g] = cyc + 1 + GAP;
            if (ins[g][6:0] == 7'h5B) m_due[g] = cyc + 2 + LAT;
            m_pi++;
        end else begin
            m_sv = 0;
            if (v[0] || v[1]) m_ps++;
        end
        cyc++;
        #1;
        chk_outputs();
        @(negedge clock);
    endtask

    function automatic logic [31:0] rnd_insn();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 3))
            0:       r[6:0] = 7'h0B;
            1:       r[6:0] = 7'h2B;
            2:       r[6:0] = 7'h5B;
            default: r[6:0] = 7'h33;
        endcase
        return r;
    endfunction

    task automatic idle_inputs();
        for (int n = 0; n < 2; n++) begin
            v[n] = 0; ins[n] = '0; s1[n] = '0; s2[n] = '0; rr[n] = 0;
        end
    endtask

    logic [3:0] gp;

    initial begin
        idle_inputs();
        scie_rd = '0;
        cyc = 0;
        model_reset();
        reset = 1'b1;
        #2 reset = 1'b0;
        v[0] = 1; ins[0] = 32'h0B;
        repeat (2) @(posedge clock);
        #1;
        chk("reset_ready0", 32'(req0_ready), 32'd0);
        chk_outputs();
        @(negedge clock);
        reset = 1'b1;

        // round robin from reset: 0,1,0,1
        for (int n = 0; n < 2; n++) begin
            v[n] = 1; ins[n] = 32'h0B; s1[n] = 32'(n + 10); s2[n] = 32'(n + 20);
        end
        for (int i = 0; i < 4; i++) begin
            #1 gp[i] = req1_ready;
            step();
            chk("rr_scie_valid", 32'(scie_valid), 32'd1);
        end
        chk("rr_pattern", 32'(gp), 32'hA);

        // single write
        v[1] = 0;
        ins[0] = 32'h0B; s1[0] = 32'd45795; s2[0] = '0;
        step();
        chk("wr_valid", 32'(scie_valid), 32'd1);
        chk("wr_insn", scie_insn, 32'h0B);
        chk("wr_rs1", scie_rs1, 32'd45795);
        chk("wr_rs2", scie_rs2, 32'd0);

        // push then read: spacing and return
        scie_rd = 32'd37688;
        ins[0] = 32'h2B; s1[0] = 32'd53935;
        step();
        ins[0] = 32'h5B; s1[0] = 32'd1;
        #1 chk("gap_ready_c1", 32'(req0_ready), 32'd0);
        step();
        #1 chk("gap_ready_c2", 32'(req0_ready), 32'd1);
        step();
        v[0] = 0;
        repeat (2) step();
        chk("rd_not_yet", 32'(rsp0_valid), 32'd0);
        step();
        chk("rd_valid", 32'(rsp0_valid), 32'd1);
        chk("rd_data", rsp0_data, 32'd37688);

        // credit stall: req0 read blocked, req1 proceeds
        v[0] = 1; ins[0] = 32'h5B;
        v[1] = 1; ins[1] = 32'h0B; s1[1] = 32'd77;
        #1;
        chk("stall_r0", 32'(req0_ready), 32'd0);
        chk("stall_r1", 32'(req1_ready), 32'd1);
        step();
        v[1] = 0; rr[0] = 1;
        #1 chk("pop_cycle_r0", 32'(req0_ready), 32'd0);
        step();
        rr[0] = 0;
        #1 chk("after_pop_r0", 32'(req0_ready), 32'd1);
        scie_rd = 32'h1234_5678;
        step();
        v[0] = 0;
        repeat (LAT + 1) step();
        chk("credit_rd_valid", 32'(rsp0_valid), 32'd1);
        chk("credit_rd_data", rsp0_data, 32'h1234_5678);
        rr[0] = 1;
        step();
        rr[0] = 0;

        // reset one cycle after a read grant
        v[0] = 1; ins[0] = 32'h5B;
        step();
        v[0] = 0;
        #2 reset = 1'b0;
        model_reset();
        #1;
        chk("async_scie_valid", 32'(scie_valid), 32'd0);
        chk("async_scie_insn", scie_insn, 32'd0);
        repeat (3) begin
            @(posedge clock);
            #1;
            chk("rst_rsp0", 32'(rsp0_valid), 32'd0);
            chk("rst_scie", 32'(scie_valid), 32'd0);
        end
        @(negedge clock);
        reset = 1'b1;
        repeat (6) step();
        v[0] = 1; ins[0] = 32'h5B; scie_rd = 32'hCAFE_0001;
        step();
        v[0] = 0;
        repeat (LAT + 1) step();
        chk("post_rst_rd", 32'(rsp0_valid), 32'd1);
        chk("post_rst_data", rsp0_data, 32'hCAFE_0001);

        // random traffic
        for (int i = 0; i < 500; i++) begin
            for (int n = 0; n < 2; n++) begin
                v[n]   = ($urandom_range(0, 3) != 0);
                ins[n] = rnd_insn();
                s1[n]  = $urandom;
                s2[n]  = $urandom;
                rr[n]  = $urandom_range(0, 1);
            end
            scie_rd = $urandom;
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/scie_issue_arbiter.md
# scie_issue_arbiter

Issue controller that shares one pipelined SCIE custom-instruction unit between two requesters (for example two RoCC-style command sources). It round-robin arbitrates valid/ready command streams, registers the winning command onto the SCIE unit's `io_valid`/`io_insn`/`io_rs1`/`io_rs2` inputs, tracks in-flight result reads through the unit's fixed latency, and returns each `io_rd` result to the requester that issued it. It also enforces the push-to-read spacing the SCIE datapath requires.

## Interface
- `XLEN`, 32: data width of rs1/rs2/rd.
- `LATENCY`, 2: cycles from `scie_valid` high to a valid `scie_rd` (range 1–4).
- `READ_GAP`, 1: minimum idle cycles between a requester's push (opcode 0x2B) and its next read (opcode 0x5B) (range 0–3).

Ports:
- `clock` in 1: the single clock.
- `reset` in 1: asynchronous, active-low reset.
- `reqN_valid` in 1 (N=0,1): command valid.
- `reqN_ready` out 1: command accepted this cycle.
- `reqN_insn` in 32: instruction word; `[6:0]` is the opcode.
- `reqN_rs1`, `reqN_rs2` in XLEN: operands.
- `rspN_valid` out 1: result held.
- `rspN_ready` in 1: result consumed.
- `rspN_data` out XLEN: result.
- `scie_valid` out 1: to the SCIE unit's `io_valid`.
- `scie_insn` out 32, `scie_rs1` out XLEN, `scie_rs2` out XLEN: to the SCIE unit.
- `scie_rd` in XLEN: from the SCIE unit's `io_rd`.

## Operation
- Opcode classes:
  - 0x0B: coefficient write, no result.
  - 0x2B: sample push, no result.
  - 0x5B: read, returns a result.
  - Any other opcode is forwarded as a no-result command.
- Eligibility: `reqN_valid` and, for reads only, all of the following:
  - `rspN_valid`=0;
  - no read from N in flight;
  - N's gap counter is 0.
- Credit is one outstanding read per requester, so a capture and a pop on the same slot never coincide.
- Arbitration:
  - One grant per cycle, round-robin among eligible requesters.
  - `last_grant` resets to 1, so requester 0 wins the first tie.
  - `last_grant` updates only on a grant.
  - `reqN_ready` is combinational from eligibility and the arbiter: it is 1 only for the granted requester.
- Issue register: on a grant, `scie_*` load the winner's fields and `scie_valid`=1. With no grant, `scie_valid`=0 and the other `scie_*` outputs hold their previous values.
- Gap counter (per requester):
  - Loaded with `READ_GAP` when a 0x2B from that requester is granted.
  - Decrements each cycle while nonzero.
  - Other opcodes do not affect it.
- In-flight tracker: a shift register of LATENCY+1 entries, each holding {read, id}. When the tail entry is a read, `scie_rd` is captured into `rspN_data` and `rspN_valid` is set to 1 for that id.
- Response slot: cleared when `rspN_valid && rspN_ready`.
- Reset (asserted at any time):
  - Clears all in-flight entries, so in-flight results are discarded.
  - Clears the gap counters and response slots.
  - `scie_*` go to 0 immediately.

## Timing
- Reset values: every output is 0, except that `reqN_ready` follows eligibility combinationally once reset deasserts.
- Request accepted in cycle t → `scie_valid` high in t+1.
- A read accepted at t → `rspN_valid` high from t+2+LATENCY until popped.
- Push at t, read from the same requester: earliest read grant is t+1+READ_GAP.
- Throughput is one command per cycle total.
- A requester whose read has no credit does not block the other requester.
- Simultaneous pop and new read grant on the same requester: the grant waits until the slot is empty in the registered state, so the read is accepted the cycle after the pop.

## Configuration
- `SCIE_ARB_PERFCNT_EN` defined: adds output `perf_issue_count` [31:0] and output `perf_stall_count` [31:0].
  - `perf_issue_count` increments per grant.
  - `perf_stall_count` increments each cycle in which any `reqN_valid`=1 and no grant occurs.
  - Both reset to 0 and wrap at 2^32.
- Undefined: the ports and the counter logic are absent; all other behaviour is identical.

## Test plan
- Single write: after reset, req0 sends insn 0x0B, rs1=45795, rs2=0 → `req0_ready`=1 the same cycle; next cycle `scie_valid`=1, `scie_insn`=0x0B, `scie_rs1`=45795, `scie_rs2`=0.
- Round-robin: req0 and req1 both hold 0x0B for 4 cycles → grants alternate 0,1,0,1; `scie_valid`=1 on four consecutive cycles.
- Read spacing and return (LATENCY=2, READ_GAP=1):
  - req0 presents 0x2B (rs1=53935) at cycle 0 and 0x5B at cycle 1.
  - `req0_ready`=0 at cycle 1; the read is granted at cycle 2.
  - The model drives `scie_rd`=37688 at cycle 5 → `rsp0_valid`=1 with `rsp0_data`=37688 from cycle 6.
- Credit stall: with `rsp0_ready`=0 and one result held, a second req0 0x5B stays not-ready while req1 0x0B is granted. After `rsp0_ready` pulses, the req0 read is granted the next cycle.
- Reset mid-flight: assert reset one cycle after a read grant, release 3 cycles later → no `rsp0_valid` ever, `scie_valid`=0, and the next read returns normally.
- `SCIE_ARB_PERFCNT_EN`:
  - 3 grants plus 2 stalled cycles (req0 read blocked, req1 idle) → `perf_issue_count`=3, `perf_stall_count`=2.
  - Preloaded near wrap, the counters roll from 0xFFFFFFFF to 0.
